// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator and pixel qualifier: scan coordinates in, aligned transparency-keyed pixel out.
// Optional horizontal mirroring is compiled in with `define SPRITE_MIRROR_EN (adds the i_flip input).
module sprite_addr_gen #(
  parameter int SPR_W  = 34,
  parameter int SPR_H  = 27,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] TRANS_KEY = 8'h00
) (
  input  logic              i_clk2,
  input  logic              i_rst,
  input  logic              i_pix_stb,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_frame_start,
  input  logic [9:0]        i_spr_x,
  input  logic [9:0]        i_spr_y,
`ifdef SPRITE_MIRROR_EN
  input  logic              i_flip,
`endif
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_pix_stb,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_sprite_on
);

  localparam int COL_W = $clog2(SPR_W);
  localparam logic [10:0] SPR_W11 = 11'(SPR_W);
  localparam logic [10:0] SPR_H11 = 11'(SPR_H);

  logic [9:0]        ax, ay;
  logic [ADDR_W-1:0] row_base;
  logic [COL_W-1:0]  col;
  logic              s1_valid, s1_hit, s2_valid, s2_hit;

  logic              frame_now;
  logic [10:0]       x11, y11, ax11, ay11;
  logic [ADDR_W-1:0] base_eff;
  logic [COL_W-1:0]  col_eff;
  logic [ADDR_W-1:0] col_term;
  logic [ADDR_W-1:0] addr_next;
  logic              hit, last_col;

`ifdef SPRITE_MIRROR_EN
  logic flip_q;
  logic flip_eff;
`endif

  // The strobe carrying frame_start sees the new origin and a cleared counter in the same cycle.
  always_comb begin
    frame_now = i_pix_stb && i_frame_start;
    x11       = {1'b0, i_x};
    y11       = {1'b0, i_y};
    ax11      = frame_now ? {1'b0, i_spr_x} : {1'b0, ax};
    ay11      = frame_now ? {1'b0, i_spr_y} : {1'b0, ay};
    base_eff  = frame_now ? '0 : row_base;
    col_eff   = frame_now ? '0 : col;
    hit       = (x11 >= ax11) && (x11 < ax11 + SPR_W11) &&
                (y11 >= ay11) && (y11 < ay11 + SPR_H11);
    last_col  = (x11 == ax11 + SPR_W11 - 11'd1);
`ifdef SPRITE_MIRROR_EN
    flip_eff  = frame_now ? i_flip : flip_q;
    col_term  = flip_eff ? (ADDR_W'(SPR_W - 1) - ADDR_W'(col_eff)) : ADDR_W'(col_eff);
`else
    col_term  = ADDR_W'(col_eff);
`endif
    addr_next = base_eff + col_term;
  end

  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      ax          <= '0;
      ay          <= '0;
      row_base    <= '0;
      col         <= '0;
      o_rom_addr  <= '0;
      s1_valid    <= 1'b0;
      s1_hit      <= 1'b0;
      s2_valid    <= 1'b0;
      s2_hit      <= 1'b0;
      o_pix_stb   <= 1'b0;
      o_pix_data  <= '0;
      o_sprite_on <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      flip_q      <= 1'b0;
`endif
    end else begin
      s1_valid  <= i_pix_stb;
      s2_valid  <= s1_valid;
      s2_hit    <= s1_hit;
      o_pix_stb <= s2_valid;

      if (i_pix_stb) begin
        s1_hit <= hit;
        if (i_frame_start) begin
          ax <= i_spr_x;
          ay <= i_spr_y;
`ifdef SPRITE_MIRROR_EN
          flip_q <= i_flip;
`endif
        end
        // Row base steps by one sprite row at the right edge, replacing a y*SPR_W multiply.
        if (hit) begin
          o_rom_addr <= addr_next;
          if (last_col) begin
            col      <= '0;
            row_base <= base_eff + ADDR_W'(SPR_W);
          end else begin
            col      <= col_eff + COL_W'(1);
            row_base <= base_eff;
          end
        end else begin
          col      <= col_eff;
          row_base <= base_eff;
        end
      end

      if (s2_valid) begin
        o_pix_data  <= s2_hit ? i_rom_data : '0;
        o_sprite_on <= s2_hit && (i_rom_data != TRANS_KEY);
      end
    end
  end

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Randomized self-checking bench for sprite_addr_gen with a coordinate-level reference model and a ROM model.
// Honours `define SPRITE_MIRROR_EN the same way as the design.
module tb_sprite_addr_gen;

  localparam int SPR_W = 34;
  localparam int SPR_H = 27;

  logic       i_clk2 = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_pix_stb = 1'b0;
  logic [9:0] i_x = '0, i_y = '0;
  logic       i_frame_start = 1'b0;
  logic [9:0] i_spr_x = '0, i_spr_y = '0;
`ifdef SPRITE_MIRROR_EN
  logic       i_flip = 1'b0;
`endif
  logic [9:0] o_rom_addr;
  logic [7:0] i_rom_data;
  logic       o_pix_stb;
  logic [7:0] o_pix_data;
  logic       o_sprite_on;

  sprite_addr_gen dut (
    .i_clk2        (i_clk2),
    .i_rst         (i_rst),
    .i_pix_stb     (i_pix_stb),
    .i_x           (i_x),
    .i_y           (i_y),
    .i_frame_start (i_frame_start),
    .i_spr_x       (i_spr_x),
    .i_spr_y       (i_spr_y),
`ifdef SPRITE_MIRROR_EN
    .i_flip        (i_flip),
`endif
    .o_rom_addr    (o_rom_addr),
    .i_rom_data    (i_rom_data),
    .o_pix_stb     (o_pix_stb),
    .o_pix_data    (o_pix_data),
    .o_sprite_on   (o_sprite_on)
  );

  always #5 i_clk2 = ~i_clk2;

  // Single-port ROM with a one-cycle registered read
  logic [7:0] rom [0:1023];
  always @(posedge i_clk2) i_rom_data <= rom[o_rom_addr];

  typedef struct {
    int         due;
    logic       hit;
    logic [9:0] addr;
  } pend_t;

  pend_t      pend_q[$];
  int         edge_cnt = 0;
  int         checks = 0;
  int         errors = 0;
  int         m_ax = 0, m_ay = 0;
  logic       m_flip = 1'b0;
  logic [9:0] m_addr = '0;
  logic [7:0] m_pix = '0;
  logic       m_on = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then advance the model and compare.
  task automatic applyStimulus(input logic rst, input logic stb, input logic fs,
                               input logic [9:0] x, input logic [9:0] y,
                               input logic [9:0] sx, input logic [9:0] sy, input logic flip);
    pend_t e;
    int    cx;
    logic  hit;
    i_rst         = rst;
    i_pix_stb     = stb;
    i_frame_start = fs;
    i_x           = x;
    i_y           = y;
    i_spr_x       = sx;
    i_spr_y       = sy;
`ifdef SPRITE_MIRROR_EN
    i_flip        = flip;
`endif
    @(posedge i_clk2);
    edge_cnt++;
    #1;
    if (rst) begin
      pend_q.delete();
      m_ax = 0; m_ay = 0; m_flip = 1'b0;
      m_addr = '0; m_pix = '0; m_on = 1'b0;
      checkOutput("rst_stb", o_pix_stb, 0);
      checkOutput("rst_addr", o_rom_addr, 0);
      checkOutput("rst_pix", o_pix_data, 0);
      checkOutput("rst_on", o_sprite_on, 0);
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due == edge_cnt) begin
        e = pend_q.pop_front();
        m_pix = e.hit ? rom[e.addr] : 8'h00;
        m_on  = e.hit && (rom[e.addr] != 8'h00);
        checkOutput("pix_stb", o_pix_stb, 1);
        checkOutput("pix_data", o_pix_data, m_pix);
        checkOutput("sprite_on", o_sprite_on, m_on);
      end else begin
        checkOutput("stb_idle", o_pix_stb, 0);
        checkOutput("pix_hold", o_pix_data, m_pix);
        checkOutput("on_hold", o_sprite_on, m_on);
      end
      if (stb) begin
        if (fs) begin
          m_ax = sx; m_ay = sy;
`ifdef SPRITE_MIRROR_EN
          m_flip = flip;
`endif
        end
        hit = (x >= m_ax) && (x < m_ax + SPR_W) && (y >= m_ay) && (y < m_ay + SPR_H);
        if (hit) begin
          cx = int'(x) - m_ax;
          if (m_flip) cx = SPR_W - 1 - cx;
          m_addr = 10'((int'(y) - m_ay) * SPR_W + cx);
        end
        e.due = edge_cnt + 2; e.hit = hit; e.addr = m_addr;
        pend_q.push_back(e);
      end
      checkOutput("rom_addr", o_rom_addr, m_addr);
    end
  endtask

  // Idle cycles also throw random frame_start and origin values at the design.
  task automatic idle(input int n, input logic rst);
    repeat (n)
      applyStimulus(rst, 1'b0, 1'($urandom_range(1)), 10'($urandom_range(799)), 10'($urandom_range(524)),
                    10'($urandom_range(799)), 10'($urandom_range(524)), 1'($urandom_range(1)));
  endtask

  // Raster-scan a window; frame_start rides the first pixel, origin inputs are noise elsewhere.
  task automatic run_frame(input int wx0, input int wy0, input int w, input int h,
                           input int ox, input int oy, input logic flip);
    logic fs;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        idle($urandom_range(2), 1'b0);
        fs = (xx == 0) && (yy == 0);
        applyStimulus(1'b0, 1'b1, fs, 10'(wx0 + xx), 10'(wy0 + yy),
                      fs ? 10'(ox) : 10'($urandom_range(799)),
                      fs ? 10'(oy) : 10'($urandom_range(524)),
                      fs ? flip : 1'($urandom_range(1)));
      end
    end
  endtask

  initial begin
    int r, wx0, wy0;
    for (int i = 0; i < 1024; i++) begin
      r = $urandom_range(3);
      rom[i] = (r == 0) ? 8'h00 : (r == 1) ? 8'hE0 : 8'($urandom);
    end
    $display("[TB] start");
    idle(3, 1'b1);
    idle(2, 1'b0);

    run_frame(96, 48, 48, 36, 100, 50, 1'b0);
    run_frame(290, 195, 48, 36, 300, 200, 1'b0);
    run_frame(96, 48, 48, 36, 100, 50, 1'b1);
    run_frame(0, 0, 48, 36, 600, 400, 1'b0);
    repeat (3) begin
      wx0 = $urandom_range(700);
      wy0 = $urandom_range(450);
      run_frame(wx0, wy0, 48, 36, wx0 + $urandom_range(14), wy0 + $urandom_range(26),
                1'($urandom_range(1)));
    end

    // Reset one cycle after a hit strobe, then two cycles after one
    idle(4, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'd100, 10'd50, 10'd100, 10'd50, 1'b0);
    idle(2, 1'b1);
    idle(5, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'd100, 10'd50, 10'd100, 10'd50, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(5, 1'b0);
    run_frame(96, 48, 40, 4, 100, 50, 1'b0);
    idle(4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
